exe_mem_stage: RTL and testbench
================================

Name: exe_mem_stage

Overview:
- Execute stage of the 5-stage pipeline CPU, directly downstream of the ID/EXE pipeline register; consumes the exe_* control and operand bundle.
- Selects ALU operands (shift amount / immediate muxing) and computes a 32-bit ALU result.
- Registers result, store data and MEM/WB control into the EXE/MEM boundary (mem_* outputs).
- Supports pipeline hold (stall) and bubble insertion (flush); exposes combinational EXE result for ID-stage forwarding.

Parameters:
- DW, 32, datapath width; only 32 is supported (shift-amount field and sign extension assume 32).
- SA_LSB, 6, LSB position of the 5-bit shift-amount field inside exe_imm (bits SA_LSB+4..SA_LSB).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- clrn  in  1  asynchronous active-low reset
- exe_m2reg  in  1  load: write-back selects memory data
- exe_wmem  in  1  store: write data memory
- exe_aluc  in  3  ALU operation code
- exe_aluimm  in  1  1: operand B = exe_imm, 0: operand B = exe_rb
- exe_shift  in  1  1: operand A = zero-extended shift amount from exe_imm, 0: operand A = exe_ra
- exe_wreg  in  1  instruction writes register file
- exe_rn  in  5  destination register number
- exe_ra  in  DW  register operand A
- exe_rb  in  DW  register operand B / store data
- exe_imm  in  DW  sign/zero-extended immediate from ID
- stall  in  1  hold all EXE/MEM registers this cycle
- flush  in  1  load a bubble into EXE/MEM this cycle
- exe_alu  out  DW  combinational ALU result (forwarding to ID)
- mem_m2reg  out  1  registered exe_m2reg
- mem_wmem  out  1  registered exe_wmem
- mem_wreg  out  1  registered exe_wreg
- mem_rn  out  5  registered exe_rn
- mem_alu  out  DW  registered ALU result (memory address / write-back value)
- mem_b  out  DW  registered exe_rb (store data; always exe_rb, never the immediate)
- mem_z  out  1  registered (ALU result == 0)

Behaviour:
- Reset: clrn low asynchronously forces mem_m2reg, mem_wmem, mem_wreg, mem_z = 0; mem_rn = 0; mem_alu, mem_b = 0. Reset mid-operation discards the in-flight instruction; first capture occurs at the first posedge after clrn deasserts.
- Operand A = exe_shift ? {27'b0, exe_imm[SA_LSB+4:SA_LSB]} : exe_ra. Operand B = exe_aluimm ? exe_imm : exe_rb.
- exe_aluc encoding: 000 ADD A+B; 001 SUB A-B; 010 AND; 011 OR; 100 XOR; 101 SLL B<<A[4:0]; 110 SRL B>>A[4:0] logical; 111 SRA B>>>A[4:0] arithmetic.
- Arithmetic: modulo 2^32, no overflow trap, no carry output. Shifts use only A[4:0]; A[31:5] ignored (shift by 32 == shift by 0).
- exe_alu purely combinational from current exe_* inputs, zero latency.
- Latency: 1 cycle; the values present at posedge N appear on mem_* after posedge N.
- Update priority at each posedge: flush > stall > normal capture.
  - flush=1: mem_wreg, mem_wmem, mem_m2reg <= 0; mem_rn <= 0; mem_alu, mem_b, mem_z unchanged (don't-care, not relied upon).
  - flush=0, stall=1: all mem_* hold previous values.
  - both 0: all mem_* <= new values.
- flush and stall asserted together: flush wins (bubble inserted, no hold).
- No internal state beyond the EXE/MEM register; no FSM.

Decomposition:
- Shared package/header: ALU opcode constants (ALU_ADD..ALU_SRA), DW, shift-amount field position; ID-stage control decoder uses the same constants.
- One sub-module: alu (combinational; inputs a, b, aluc; outputs r, z); instantiated once here. Operand muxes and the register stay in exe_mem_stage.

Test Plan:
- Reset: drive random inputs, pulse clrn low between edges -> all mem_* read 0 immediately, without waiting for a clock edge.
- ADD/SUB/immediate: ra=0x7FFFFFFF, imm=1, aluimm=1, aluc=000 -> exe_alu=0x80000000 same cycle, mem_alu=0x80000000 after next edge; ra=5, rb=5, aluc=001 -> mem_alu=0, mem_z=1.
- Shifts: shift=1, imm[10:6]=4, rb=0x80000010, aluc=101/110/111 -> 0x00000100 / 0x08000001 / 0xF8000001; shift=0, ra=0x21, rb=1, aluc=101 -> 0x00000002.
- Store path: wmem=1, aluimm=1, ra=0x100, imm=0x8, rb=0xDEADBEEF -> mem_alu=0x108, mem_b=0xDEADBEEF, mem_wmem=1.
- Stall: capture wreg=1, rn=3, alu=0x55; then stall=1 for 2 cycles with changed inputs -> mem_* stay rn=3, 0x55, wreg=1; release -> new values appear after 1 edge.
- Flush vs stall: wreg=1, wmem=1, m2reg=1, rn=9 with flush=1, stall=1 -> after edge mem_wreg=mem_wmem=mem_m2reg=0, mem_rn=0.

Source files
------------

// File: rtl/exe_mem_stage_pkg.sv
// Shared EXE-stage definitions: datapath width, shift-amount field position
// and ALU opcodes, also used by the ID-stage control decoder.
package exe_mem_stage_pkg;

  localparam int DATA_W = 32;
  localparam int SA_POS = 6;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } aluc_e;

endpackage

// File: rtl/exe_mem_stage_alu.sv
// Combinational 32-bit ALU with zero flag; no carry or overflow output.
// Shifts move operand b by a[4:0]; the upper bits of a are ignored.
module alu
  import exe_mem_stage_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        aluc,
  output logic [DATA_W-1:0] r,
  output logic              z
);

  logic [4:0] w_sa;
  assign w_sa = a[4:0];

  always_comb begin
    r = '0;
    case (aluc_e'(aluc))
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_XOR: r = a ^ b;
      ALU_SLL: r = b << w_sa;
      ALU_SRL: r = b >> w_sa;
      ALU_SRA: r = $unsigned($signed(b) >>> w_sa);
      default: r = '0;
    endcase
  end

  assign z = (r == '0);

endmodule

// File: rtl/exe_mem_stage.sv
// Execute stage: operand muxing, ALU, and the EXE/MEM pipeline register.
// One-cycle latency; flush inserts a bubble and takes priority over stall.
module exe_mem_stage
  import exe_mem_stage_pkg::*;
#(
  parameter int DW     = DATA_W,
  parameter int SA_LSB = SA_POS
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          exe_m2reg,
  input  logic          exe_wmem,
  input  logic [2:0]    exe_aluc,
  input  logic          exe_aluimm,
  input  logic          exe_shift,
  input  logic          exe_wreg,
  input  logic [4:0]    exe_rn,
  input  logic [DW-1:0] exe_ra,
  input  logic [DW-1:0] exe_rb,
  input  logic [DW-1:0] exe_imm,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] exe_alu,
  output logic          mem_m2reg,
  output logic          mem_wmem,
  output logic          mem_wreg,
  output logic [4:0]    mem_rn,
  output logic [DW-1:0] mem_alu,
  output logic [DW-1:0] mem_b,
  output logic          mem_z
);

  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [DW-1:0] w_r;
  logic          w_z;

  logic          r_m2reg;
  logic          r_wmem;
  logic          r_wreg;
  logic [4:0]    r_rn;
  logic [DW-1:0] r_alu;
  logic [DW-1:0] r_b;
  logic          r_z;

  assign w_a = exe_shift ? {{(DW-5){1'b0}}, exe_imm[SA_LSB+4:SA_LSB]} : exe_ra;
  assign w_b = exe_aluimm ? exe_imm : exe_rb;

  alu u_alu (
    .a    (w_a),
    .b    (w_b),
    .aluc (exe_aluc),
    .r    (w_r),
    .z    (w_z)
  );

  assign exe_alu = w_r;

  // A bubble only clears control and rn; data fields are left as they were.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_wreg  <= 1'b0;
      r_rn    <= '0;
      r_alu   <= '0;
      r_b     <= '0;
      r_z     <= 1'b0;
    end else if (flush) begin
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_wreg  <= 1'b0;
      r_rn    <= '0;
    end else if (!stall) begin
      r_m2reg <= exe_m2reg;
      r_wmem  <= exe_wmem;
      r_wreg  <= exe_wreg;
      r_rn    <= exe_rn;
      r_alu   <= w_r;
      r_b     <= exe_rb;
      r_z     <= w_z;
    end
  end

  assign mem_m2reg = r_m2reg;
  assign mem_wmem  = r_wmem;
  assign mem_wreg  = r_wreg;
  assign mem_rn    = r_rn;
  assign mem_alu   = r_alu;
  assign mem_b     = r_b;
  assign mem_z     = r_z;

endmodule

// File: tb/tb_exe_mem_stage.sv
// Bench for exe_mem_stage: directed cases plus randomized traffic against a
// behavioural model of the ALU and the EXE/MEM register.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        exe_m2reg, exe_wmem, exe_aluimm, exe_shift, exe_wreg;
  logic [2:0]  exe_aluc;
  logic [4:0]  exe_rn;
  logic [31:0] exe_ra, exe_rb, exe_imm;
  logic        stall, flush;
  logic [31:0] exe_alu;
  logic        mem_m2reg, mem_wmem, mem_wreg, mem_z;
  logic [4:0]  mem_rn;
  logic [31:0] mem_alu, mem_b;

  always #5 clk = ~clk;

  exe_mem_stage dut (
    .clk        (clk),
    .clrn       (clrn),
    .exe_m2reg  (exe_m2reg),
    .exe_wmem   (exe_wmem),
    .exe_aluc   (exe_aluc),
    .exe_aluimm (exe_aluimm),
    .exe_shift  (exe_shift),
    .exe_wreg   (exe_wreg),
    .exe_rn     (exe_rn),
    .exe_ra     (exe_ra),
    .exe_rb     (exe_rb),
    .exe_imm    (exe_imm),
    .stall      (stall),
    .flush      (flush),
    .exe_alu    (exe_alu),
    .mem_m2reg  (mem_m2reg),
    .mem_wmem   (mem_wmem),
    .mem_wreg   (mem_wreg),
    .mem_rn     (mem_rn),
    .mem_alu    (mem_alu),
    .mem_b      (mem_b),
    .mem_z      (mem_z)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Expected contents of the EXE/MEM register
  logic        e_m2reg, e_wmem, e_wreg, e_z;
  logic [4:0]  e_rn;
  logic [31:0] e_alu, e_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned s;
    logic [31:0] fill;
    s = a % 32;
    fill = b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a + (~b + 32'd1);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return b << s;
      3'd6:    return b >> s;
      default: return (b >> s) | fill;
    endcase
  endfunction

  function automatic logic [31:0] cur_result();
    logic [31:0] a, b;
    a = exe_shift ? ((exe_imm >> 6) & 32'd31) : exe_ra;
    b = exe_aluimm ? exe_imm : exe_rb;
    return ref_alu(exe_aluc, a, b);
  endfunction

  task automatic model_reset();
    e_m2reg = 0; e_wmem = 0; e_wreg = 0; e_z = 0;
    e_rn = 0; e_alu = 0; e_b = 0;
  endtask

  task automatic check_mem(input string tag);
    check({tag, ".m2reg"}, {31'd0, mem_m2reg}, {31'd0, e_m2reg});
    check({tag, ".wmem"},  {31'd0, mem_wmem},  {31'd0, e_wmem});
    check({tag, ".wreg"},  {31'd0, mem_wreg},  {31'd0, e_wreg});
    check({tag, ".rn"},    {27'd0, mem_rn},    {27'd0, e_rn});
    check({tag, ".alu"},   mem_alu, e_alu);
    check({tag, ".b"},     mem_b,   e_b);
    check({tag, ".z"},     {31'd0, mem_z},     {31'd0, e_z});
  endtask

  task automatic set_in(input logic m2reg, input logic wmem, input logic [2:0] aluc,
                        input logic aluimm, input logic shift, input logic wreg,
                        input logic [4:0] rn, input logic [31:0] ra, input logic [31:0] rb,
                        input logic [31:0] imm, input logic st, input logic fl);
    exe_m2reg = m2reg; exe_wmem = wmem; exe_aluc = aluc; exe_aluimm = aluimm;
    exe_shift = shift; exe_wreg = wreg; exe_rn = rn; exe_ra = ra; exe_rb = rb;
    exe_imm = imm; stall = st; flush = fl;
  endtask

  task automatic set_random();
    set_in($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
           5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15));
  endtask

  // Called with inputs applied and away from the edge: check exe_alu,
  // advance the model across one posedge, then check the register.
  task automatic step(input string tag);
    logic [31:0] r;
    #1;
    r = cur_result();
    check({tag, ".exe_alu"}, exe_alu, r);
    if (flush) begin
      e_m2reg = 0; e_wmem = 0; e_wreg = 0; e_rn = 0;
    end else if (!stall) begin
      e_m2reg = exe_m2reg; e_wmem = exe_wmem; e_wreg = exe_wreg; e_rn = exe_rn;
      e_alu = r; e_b = exe_rb; e_z = (r == 32'd0);
    end
    @(posedge clk);
    #1;
    check_mem(tag);
  endtask

  initial begin
    clrn = 1'b1;
    set_random();
    stall = 0; flush = 0;
    model_reset();
    #2;
    clrn = 1'b0;
    #1;
    check_mem("reset_async");
    @(posedge clk); #1;
    check_mem("reset_hold");
    @(negedge clk);
    clrn = 1'b1;

    // ADD with immediate crossing into the sign bit, then SUB to zero
    set_in(0, 0, 3'd0, 1, 0, 1, 5'd1, 32'h7FFF_FFFF, 32'h1234_5678, 32'h1, 0, 0);
    step("add_imm");
    check("add_imm.value", mem_alu, 32'h8000_0000);
    set_in(0, 0, 3'd1, 0, 0, 1, 5'd2, 32'd5, 32'd5, 32'hFFFF_FFFF, 0, 0);
    step("sub_zero");
    check("sub_zero.z", {31'd0, mem_z}, 32'd1);

    // Shifts by sa field (imm[10:6] = 4) and by ra with bit 5 set
    set_in(0, 0, 3'd5, 0, 1, 1, 5'd4, 32'hFFFF_FFFF, 32'h8000_0010, 32'h0000_0100, 0, 0);
    step("sll_sa");
    check("sll_sa.value", mem_alu, 32'h0000_0100);
    exe_aluc = 3'd6;
    step("srl_sa");
    check("srl_sa.value", mem_alu, 32'h0800_0001);
    exe_aluc = 3'd7;
    step("sra_sa");
    check("sra_sa.value", mem_alu, 32'hF800_0001);
    set_in(0, 0, 3'd5, 0, 0, 1, 5'd5, 32'h21, 32'h1, 32'h0, 0, 0);
    step("sll_ra");
    check("sll_ra.value", mem_alu, 32'h0000_0002);

    // Store: address from ra+imm, data always rb
    set_in(0, 1, 3'd0, 1, 0, 0, 5'd0, 32'h100, 32'hDEAD_BEEF, 32'h8, 0, 0);
    step("store");
    check("store.addr", mem_alu, 32'h108);
    check("store.data", mem_b, 32'hDEAD_BEEF);

    // Stall holds for two cycles, release captures new values
    set_in(0, 0, 3'd0, 0, 0, 1, 5'd3, 32'h55, 32'h0, 32'h0, 0, 0);
    step("stall_cap");
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 3'd4, 1, 0, 0, 5'd17, 32'hA5A5_0000, 32'h1111, 32'h0F0F, 1, 0);
      step("stall_hold");
      check("stall_hold.rn", {27'd0, mem_rn}, 32'd3);
      check("stall_hold.alu", mem_alu, 32'h55);
    end
    stall = 0;
    step("stall_release");
    check("stall_release.rn", {27'd0, mem_rn}, 32'd17);

    // Flush and stall together: bubble wins
    set_in(1, 1, 3'd0, 0, 0, 1, 5'd9, 32'h1, 32'h2, 32'h3, 1, 1);
    step("flush_stall");
    check("flush_stall.rn", {27'd0, mem_rn}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      set_random();
      step("rand");
    end

    // Reset in the middle of traffic discards the held instruction
    set_in(1, 1, 3'd3, 0, 0, 1, 5'd21, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0, 0, 0);
    step("pre_reset");
    clrn = 1'b0;
    #1;
    model_reset();
    check_mem("mid_reset");
    @(negedge clk);
    clrn = 1'b1;
    set_random();
    stall = 0; flush = 0;
    step("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
